// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the sdram controller.
//   pN_req/we/addr/din : request side, driven by requester N (0=ROM download, 1=CPU, 2=tape/DMA)
//   pN_ack/dout        : completion pulse and read data back to requester N
//   mem_*              : single-access bus towards the sdram controller
//   busy/grant         : arbiter status (grant = owning port, 2'd3 when none)
// Modport slave is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [7:0]        p0_din;
    logic              p0_ack;
    logic [7:0]        p0_dout;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [7:0]        p1_din;
    logic              p1_ack;
    logic [7:0]        p1_dout;

    logic              p2_req;
    logic              p2_we;
    logic [ADDR_W-1:0] p2_addr;
    logic [7:0]        p2_din;
    logic              p2_ack;
    logic [7:0]        p2_dout;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_oe;
    logic [7:0]        mem_dout;

    logic              busy;
    logic [1:0]        grant;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_din,
        input  p1_req, p1_we, p1_addr, p1_din,
        input  p2_req, p2_we, p2_addr, p2_din,
        input  mem_dout,
        output p0_ack, p0_dout, p1_ack, p1_dout, p2_ack, p2_dout,
        output mem_addr, mem_din, mem_we, mem_oe,
        output busy, grant
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_din,
        output p1_req, p1_we, p1_addr, p1_din,
        output p2_req, p2_we, p2_addr, p2_din,
        output mem_dout,
        input  p0_ack, p0_dout, p1_ack, p1_dout, p2_ack, p2_dout,
        input  mem_addr, mem_din, mem_we, mem_oe,
        input  busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port arbiter in front of an 8-bit sdram controller.
// Port 0 (ROM download) has strict priority; ports 1 (CPU) and 2 (tape/DMA)
// share the remaining bandwidth round-robin. One access at a time, each held
// on the memory bus for ACCESS_CYCLES clocks, followed by a one-cycle ack.
//   clock   : single clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : mem_arbiter_if.slave (requests, acks, read data, memory bus, status)
//
// state  | meaning
// IDLE   | bus free; winner picked and captured when any request is present
// ACCESS | captured request driven on mem_*; lasts ACCESS_CYCLES cycles
// DONE   | ack pulse to the owning port; round-robin pointer updated
module mem_arbiter #(
    parameter int ADDR_W        = 25,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
    localparam logic [1:0] NO_PORT  = 2'd3;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              rr_prefer_p2;
    logic [1:0]        owner;
    logic [1:0]        winner;
    logic              any_req;
    logic              last_cycle;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [7:0]        acc_din;
    logic [7:0]        dout0;
    logic [7:0]        dout1;
    logic [7:0]        dout2;

    always_comb begin
        winner = NO_PORT;
        if (bus.p0_req) begin
            winner = 2'd0;
        end else if (bus.p1_req && bus.p2_req) begin
            winner = rr_prefer_p2 ? 2'd2 : 2'd1;
        end else if (bus.p1_req) begin
            winner = 2'd1;
        end else if (bus.p2_req) begin
            winner = 2'd2;
        end
    end

    assign any_req    = (winner != NO_PORT);
    assign last_cycle = (state == ACCESS) && (cnt == LAST_CNT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (last_cycle) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt          <= 4'd0;
            owner        <= NO_PORT;
            rr_prefer_p2 <= 1'b0;
            acc_we       <= 1'b0;
            acc_addr     <= '0;
            acc_din      <= 8'h00;
            dout0        <= 8'h00;
            dout1        <= 8'h00;
            dout2        <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt   <= 4'd0;
                        owner <= winner;
                        case (winner)
                            2'd0: begin
                                acc_we   <= bus.p0_we;
                                acc_addr <= bus.p0_addr;
                                acc_din  <= bus.p0_din;
                            end
                            2'd1: begin
                                acc_we   <= bus.p1_we;
                                acc_addr <= bus.p1_addr;
                                acc_din  <= bus.p1_din;
                            end
                            2'd2: begin
                                acc_we   <= bus.p2_we;
                                acc_addr <= bus.p2_addr;
                                acc_din  <= bus.p2_din;
                            end
                            default: ;
                        endcase
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // read data is taken on the final bus cycle, before the bus is released
                    if (last_cycle && !acc_we) begin
                        case (owner)
                            2'd0:    dout0 <= bus.mem_dout;
                            2'd1:    dout1 <= bus.mem_dout;
                            2'd2:    dout2 <= bus.mem_dout;
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    // only ports 1 and 2 move the pointer; a port 0 access leaves it alone
                    if (owner == 2'd1) begin
                        rr_prefer_p2 <= 1'b1;
                    end else if (owner == 2'd2) begin
                        rr_prefer_p2 <= 1'b0;
                    end
                    owner <= NO_PORT;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we   = (state == ACCESS) && acc_we;
    assign bus.mem_oe   = (state == ACCESS) && !acc_we;
    assign bus.mem_addr = (state == ACCESS) ? acc_addr : '0;
    assign bus.mem_din  = (state == ACCESS) ? acc_din : 8'h00;

    assign bus.p0_ack  = (state == DONE) && (owner == 2'd0);
    assign bus.p1_ack  = (state == DONE) && (owner == 2'd1);
    assign bus.p2_ack  = (state == DONE) && (owner == 2'd2);
    assign bus.p0_dout = dout0;
    assign bus.p1_dout = dout1;
    assign bus.p2_dout = dout2;

    assign bus.busy  = (state != IDLE);
    assign bus.grant = owner;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int ADDR_W = 25;
    localparam int AC     = 3;

    typedef struct {
        logic [1:0]        port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   failed  = 0;
    int   oe_cnt  = 0;
    int   we_cnt  = 0;
    exp_t sb[$];
    int   ack_log[$];

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    // memory model: read data = low address byte + 0x65
    assign bus.mem_dout = bus.mem_oe ? (bus.mem_addr[7:0] + 8'h65) : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] port, input logic we,
                                input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    function automatic logic [7:0] dout_of(input logic [1:0] p);
        case (p)
            2'd0:    return bus.p0_dout;
            2'd1:    return bus.p1_dout;
            default: return bus.p2_dout;
        endcase
    endfunction

    // monitor: checks the memory bus against the pending access and pops on ack
    always @(negedge clock) begin
        logic [2:0] acks;
        exp_t       e;
        if (reset_n) begin
            acks = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
            if (bus.mem_oe) oe_cnt++;
            if (bus.mem_we) we_cnt++;
            if (bus.mem_oe || bus.mem_we) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL bus_unexpected: grant %0d active with nothing pending", bus.grant);
                end else begin
                    e = sb[0];
                    check("bus_grant", 32'(bus.grant), 32'(e.port));
                    check("bus_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("bus_we_oe", 32'({bus.mem_we, bus.mem_oe}), 32'({e.we, !e.we}));
                    if (e.we) check("bus_din", 32'(bus.mem_din), 32'(e.data));
                end
            end else begin
                check("bus_idle_addr", 32'(bus.mem_addr), 32'd0);
                check("bus_idle_din", 32'(bus.mem_din), 32'd0);
            end
            if (acks != 3'b000) begin
                check("ack_onehot", 32'($countones(acks)), 32'd1);
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL ack_unexpected: acks %b with nothing pending", acks);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 32'(acks), 32'(3'b001 << e.port));
                    if (!e.we) check("ack_dout", 32'(dout_of(e.port)), 32'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic serve(input int n_acks, input bit hold, input int budget, output int n);
        n = 0;
        while (ack_log.size() < n_acks && n < budget) begin
            @(negedge clock);
            n++;
            if (bus.p0_ack) begin ack_log.push_back(0); if (!hold) bus.p0_req = 1'b0; end
            if (bus.p1_ack) begin ack_log.push_back(1); if (!hold) bus.p1_req = 1'b0; end
            if (bus.p2_ack) begin ack_log.push_back(2); if (!hold) bus.p2_req = 1'b0; end
        end
        if (ack_log.size() < n_acks) check("serve_timeout", 32'(ack_log.size()), 32'(n_acks));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_grant"}, 32'(bus.grant), 32'd3);
        check({tag, "_acks"}, 32'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 32'd0);
        check({tag, "_douts"}, 32'({bus.p2_dout, bus.p1_dout, bus.p0_dout}), 32'd0);
        check({tag, "_mem_ctl"}, 32'({bus.mem_we, bus.mem_oe}), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    task automatic wait_busy(input string tag);
        int k;
        k = 0;
        while (!bus.busy && k < 10) begin
            tick();
            k++;
        end
        if (!bus.busy) check({tag, "_grant_timeout"}, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int oe0;
        int we0;
        int busy_cnt;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_din = 8'h00;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_din = 8'h00;
        bus.p2_req = 1'b0; bus.p2_we = 1'b0; bus.p2_addr = '0; bus.p2_din = 8'h00;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset("por");
        tick();
        reset_n = 1'b1;

        // single p1 read
        tick();
        ack_log.delete();
        oe0 = oe_cnt;
        bus.p1_we = 1'b0; bus.p1_addr = 25'h40; bus.p1_req = 1'b1;
        sb.push_back(mk(2'd1, 1'b0, 25'h40, 8'hA5));
        serve(1, 1'b0, 20, n);
        check("p1_latency", 32'(n - 1), 32'(AC + 1));
        check("p1_dout", 32'(bus.p1_dout), 32'hA5);
        repeat (3) @(negedge clock);
        check("p1_oe_cycles", 32'(oe_cnt - oe0), 32'd3);
        check("p1_dout_hold", 32'(bus.p1_dout), 32'hA5);
        check("p1_idle_after", 32'(bus.busy), 32'd0);

        // reset pulse clears read data and the pointer
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst2_p1_dout", 32'(bus.p1_dout), 32'd0);

        // p0 write against simultaneous p1/p2 reads
        tick();
        ack_log.delete();
        oe0 = oe_cnt;
        we0 = we_cnt;
        bus.p0_we = 1'b1; bus.p0_addr = 25'h123; bus.p0_din = 8'h3C;
        bus.p1_we = 1'b0; bus.p1_addr = 25'h10;
        bus.p2_we = 1'b0; bus.p2_addr = 25'h20;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        sb.push_back(mk(2'd0, 1'b1, 25'h123, 8'h3C));
        sb.push_back(mk(2'd1, 1'b0, 25'h10, 8'h75));
        sb.push_back(mk(2'd2, 1'b0, 25'h20, 8'h85));
        serve(3, 1'b0, 60, n);
        check("prio_order", 32'({ack_log[0][1:0], ack_log[1][1:0], ack_log[2][1:0]}), 32'b00_01_10);
        check("prio_issue_rate", 32'(n), 32'd15);
        check("prio_we_cycles", 32'(we_cnt - we0), 32'd3);
        check("prio_oe_cycles", 32'(oe_cnt - oe0), 32'd6);
        check("prio_p1_dout", 32'(bus.p1_dout), 32'h75);
        check("prio_p2_dout", 32'(bus.p2_dout), 32'h85);

        // continuous p1/p2 requests alternate
        tick();
        ack_log.delete();
        bus.p1_addr = 25'h30; bus.p2_addr = 25'h31;
        bus.p1_req = 1'b1; bus.p2_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) sb.push_back(mk(2'd1, 1'b0, 25'h30, 8'h95));
            else            sb.push_back(mk(2'd2, 1'b0, 25'h31, 8'h96));
        end
        serve(6, 1'b1, 100, n);
        bus.p1_req = 1'b0; bus.p2_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < ack_log.size()) check("rr_order", 32'(ack_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        repeat (2) @(negedge clock);
        check("rr_idle_after", 32'(bus.busy), 32'd0);

        // p2 drops its request one cycle after grant
        tick();
        ack_log.delete();
        bus.p2_addr = 25'h50; bus.p2_req = 1'b1;
        sb.push_back(mk(2'd2, 1'b0, 25'h50, 8'hB5));
        wait_busy("drop");
        check("drop_grant", 32'(bus.grant), 32'd2);
        tick();
        bus.p2_req = 1'b0;
        serve(1, 1'b0, 20, n);
        check("drop_p2_dout", 32'(bus.p2_dout), 32'hB5);
        busy_cnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.busy) busy_cnt++;
        end
        check("drop_no_regrant", 32'(busy_cnt), 32'd0);
        check("drop_grant_none", 32'(bus.grant), 32'd3);

        // reset in second ACCESS cycle of a p0 write
        tick();
        ack_log.delete();
        bus.p0_we = 1'b1; bus.p0_addr = 25'h123; bus.p0_din = 8'h3C; bus.p0_req = 1'b1;
        sb.push_back(mk(2'd0, 1'b1, 25'h123, 8'h3C));
        wait_busy("abort");
        tick();
        check("abort_we_before", 32'(bus.mem_we), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check_reset("abort");
        check("abort_no_ack", 32'(ack_log.size()), 32'd0);
        @(negedge clock);
        check("abort_regrant", 32'({bus.busy, bus.grant}), 32'b1_00);
        serve(1, 1'b0, 20, n);
        check("abort_single_ack", 32'(ack_log.size()), 32'd1);
        if (ack_log.size() > 0) check("abort_ack_port", 32'(ack_log[0]), 32'd0);

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, width of every address bus (matches sdram addr).
REQ-002 Parameter ACCESS_CYCLES, default 3, clock cycles a granted access is held on the memory bus before read data is sampled; legal range 1..15.
REQ-003 clock  in  1  single clock; every register is updated on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 pN_req  in  1  request from port N (N=0,1,2; 0=ROM download, 1=CPU, 2=tape/DMA engine).
REQ-006 pN_we  in  1  port N access type: 1 write, 0 read; sampled at grant.
REQ-007 pN_addr  in  ADDR_W  port N byte address; sampled at grant.
REQ-008 pN_din  in  8  port N write data; sampled at grant.
REQ-009 pN_ack  out  1  one-cycle pulse marking completion of port N access.
REQ-010 pN_dout  out  8  port N read data; valid from the ack cycle until the next port N read completes.
REQ-011 mem_addr  out  ADDR_W  address to sdram controller.
REQ-012 mem_din  out  8  write data to sdram controller.
REQ-013 mem_we  out  1  write strobe to sdram controller.
REQ-014 mem_oe  out  1  read enable to sdram controller.
REQ-015 mem_dout  in  8  read data from sdram controller.
REQ-016 busy  out  1  high while state is not IDLE.
REQ-017 grant  out  2  index of port owning the bus; 2'd3 when none.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any pN_req=1; ACCESS->DONE after exactly ACCESS_CYCLES cycles in ACCESS; DONE->IDLE unconditionally.
REQ-019 In IDLE the winner is chosen in the same cycle IDLE->ACCESS is taken; port 0 has strict priority over ports 1 and 2.
REQ-020 Ports 1 and 2 are served round-robin: a 1-bit pointer selects the preferred port when both request; pointer moves to the other port after each completed port 1 or port 2 access; port 0 accesses do not move it; pointer resets to prefer port 1.
REQ-021 On grant, pN_we/addr/din of the winner are registered; mem_addr, mem_din, mem_we (=we) and mem_oe (=!we) are driven from these registers during every ACCESS cycle only.
REQ-022 Outside ACCESS, mem_we=0, mem_oe=0, mem_addr=0, mem_din=0.
REQ-023 For reads, mem_dout is sampled on the final ACCESS cycle into pN_dout of the granted port; other ports' pN_dout are unchanged.
REQ-024 pN_ack of the granted port is 1 for exactly the DONE cycle; at most one ack is high in any cycle.
REQ-025 Latency: request seen in IDLE -> ack asserted ACCESS_CYCLES+1 cycles later; minimum one IDLE cycle between consecutive accesses (issue rate one per ACCESS_CYCLES+2 cycles).
REQ-026 Requesters hold pN_req high until pN_ack; a request deasserted after grant does not abort the access and ack is still issued; a request deasserted before grant is never served.
REQ-027 A requester keeping pN_req high in the ack cycle is treated as a new request at the next IDLE.
REQ-028 Sustained port 0 requests starve ports 1 and 2 (intended: CPU is held in reset during download).
REQ-029 Access counter is 4 bits, cleared on entry to ACCESS, no wrap within a legal ACCESS_CYCLES.

Reset
REQ-030 reset_n=0 at a clock edge forces state IDLE, grant=2'd3, busy=0, all pN_ack=0, all pN_dout=8'h00, mem_* =0, round-robin pointer to port 1.
REQ-031 Reset asserted during ACCESS or DONE aborts the access with no ack and no further mem_we; the interrupted request is re-arbitrated after reset if still asserted.

Verification
REQ-032 ACCESS_CYCLES=3, p1 read addr 0x0040, mem_dout=8'hA5 -> mem_oe high 3 cycles, p1_ack one cycle 4 cycles after request, p1_dout=8'hA5.
REQ-033 p0 write 0x0123 data 8'h3C simultaneous with p1 and p2 reads -> grant order 0,1,2; mem_we only during p0 ACCESS with mem_din=8'h3C.
REQ-034 p1 and p2 request continuously for 6 accesses -> grants alternate 1,2,1,2,1,2; acks never overlap.
REQ-035 p2 drops req one cycle after grant -> access completes, p2_ack still pulses, next IDLE does not grant p2.
REQ-036 reset_n low for one cycle in second ACCESS cycle of p0 write -> mem_we=0 next cycle, no p0_ack, all outputs at reset values, p0 re-granted after reset with held req.
